// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory pipeline stage of a 32-bit in-order core.
//
// Takes one EX-stage result per handshake. ALU/branch results pass straight
// into the registered writeback slot. Loads and stores issue a single data
// memory request and complete when the memory acknowledges it.
//
// Optional feature (compile-time macro):
//   MEM_MISALIGN_TRAP_EN  When defined, misaligned halfword/word accesses are
//                         not issued. They complete in one cycle with
//                         misalign=1. When undefined, misalign is always 0 and
//                         the low address bits below the access size are ignored.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   in_valid/in_ready EX result handshake
//   alu_result        byte address (load/store) or writeback value
//   store_data        rs2 value for stores
//   opcode, funct3    instruction class and access size/sign
//   rd                destination register
//   dmem_req/dmem_we  memory request and write enable, held until dmem_ack
//   dmem_addr         word-aligned address
//   dmem_wdata/wstrb  replicated store data and byte-lane enables
//   dmem_ack/rdata    request completion and read word
//   out_valid/ready   writeback handshake
//   out_result/out_rd/out_rf_we  writeback value, register, write enable
//   misalign          misaligned-access flag, qualified by out_valid
// -----------------------------------------------------------------------------
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_rf_we,
  output logic        misalign
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t state, state_next;

  // Decode of the EX result currently presented.
  logic        is_load, is_store, is_branch;
  logic        load_ok, store_ok;
  logic        misaligned;
  logic        mem_go;
  logic [1:0]  lane_off;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] imm_result;
  logic        imm_rf_we;

  // Handshake events.
  logic        accept;
  logic        mem_done;

  // Context of the access in flight, needed when the ack returns.
  logic        acc_is_load;
  logic [2:0]  acc_funct3;
  logic [1:0]  acc_off;
  logic [4:0]  acc_rd;
  logic [31:0] acc_result;
  logic [31:0] load_data;

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  return {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  return {24'h0, shifted[7:0]};
      3'b101:  return {16'h0, shifted[15:0]};
      default: return word;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    is_branch = (opcode == OP_BRANCH);

    load_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: load_ok = 1'b1;
      default:                                load_ok = 1'b0;
    endcase
    store_ok = (funct3 < 3'b011);

    // Effective byte offset: address bits below the access size are dropped,
    // which also defines the lane used by a misaligned access when not trapped.
    lane_off = 2'b00;
    case (funct3[1:0])
      2'b00:   lane_off = alu_result[1:0];
      2'b01:   lane_off = {alu_result[1], 1'b0};
      default: lane_off = 2'b00;
    endcase

    st_wdata = store_data;
    st_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{store_data[7:0]}};
        st_wstrb = 4'b0001 << lane_off;
      end
      2'b01: begin
        st_wdata = {2{store_data[15:0]}};
        st_wstrb = 4'b0011 << lane_off;
      end
      default: begin
        st_wdata = store_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = ((is_load && load_ok) || (is_store && store_ok)) &&
                      (((funct3[1:0] == 2'b01) && alu_result[0]) ||
                       ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign mem_go = ((is_load && load_ok) || (is_store && store_ok)) && !misaligned;

  // Value written into the out slot when the op completes without memory.
  always_comb begin
    imm_result = alu_result;
    imm_rf_we  = 1'b0;
    if (misaligned) begin
      imm_result = alu_result;
      imm_rf_we  = 1'b0;
    end else if (is_load || is_store) begin
      // Unsupported access size: completes as a no-op.
      imm_result = 32'h0;
      imm_rf_we  = 1'b0;
    end else begin
      imm_result = alu_result;
      imm_rf_we  = !is_branch && (rd != 5'd0);
    end
  end

  assign load_data = load_extract(dmem_rdata, acc_funct3, acc_off);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: asynchronous reset sits in the sensitivity list so the state clears
  // immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    mem_done   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
        if (accept && mem_go) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        // An ack is only meaningful while a request is outstanding.
        mem_done = dmem_req && dmem_ack;
        if (mem_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory request registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'h0;
      dmem_wdata  <= 32'h0;
      dmem_wstrb  <= 4'h0;
      acc_is_load <= 1'b0;
      acc_funct3  <= 3'h0;
      acc_off     <= 2'h0;
      acc_rd      <= 5'h0;
      acc_result  <= 32'h0;
    end else if (accept && mem_go) begin
      dmem_req    <= 1'b1;
      dmem_we     <= is_store;
      dmem_addr   <= {alu_result[31:2], 2'b00};
      dmem_wdata  <= is_store ? st_wdata : 32'h0;
      dmem_wstrb  <= is_store ? st_wstrb : 4'h0;
      acc_is_load <= is_load;
      acc_funct3  <= funct3;
      acc_off     <= lane_off;
      acc_rd      <= rd;
      acc_result  <= alu_result;
    end else if (mem_done) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_wstrb <= 4'h0;
    end
  end

  // ---------------------------------------------------------------------------
  // Writeback slot
  // ---------------------------------------------------------------------------
  // The slot is only refilled on accept (which requires it free or draining)
  // or on an ack (it is always empty during ACCESS), so a stalled result is
  // never overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= 32'h0;
      out_rd     <= 5'h0;
      out_rf_we  <= 1'b0;
      misalign   <= 1'b0;
    end else if (accept && !mem_go) begin
      out_valid  <= 1'b1;
      out_result <= imm_result;
      out_rd     <= rd;
      out_rf_we  <= imm_rf_we;
      misalign   <= misaligned;
    end else if (mem_done) begin
      out_valid  <= 1'b1;
      out_result <= acc_is_load ? load_data : acc_result;
      out_rd     <= acc_rd;
      out_rf_we  <= acc_is_load && (acc_rd != 5'd0);
      misalign   <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
